// File: rtl/segment_selector.sv
// -----------------------------------------------------------------------------
// segment_selector
//
// Weighted segment chooser that feeds the segment-select side of the Sampler.
// The controller loads a small table of candidate segments (from, to, type,
// weight). When a selection is requested, an 8-bit LFSR supplies a
// pseudo-random number, which is scaled into the range [0, total_weight). The
// table is then scanned one entry per cycle, accumulating weights until the
// running sum exceeds the scaled number. The entry reached this way is handed
// to the Sampler. Each segment is therefore chosen with probability
// proportional to its weight.
//
// Handshake (out_valid / in_ready):
//   The result transfers on a posedge where out_valid=1 and in_ready=1.
//   Once out_valid is high, it stays high and every out_* field holds its
//   value until that transfer completes. out_valid never drops without a
//   transfer, except when reset is applied.
//
// Ports:
//   in_clock            system clock, all logic on posedge
//   in_reset            synchronous, active-low reset
//   in_seed             LFSR seed, captured while in_reset=0 (0 maps to 8'h01)
//   in_load_clear       empty the table (IDLE only, beats load/start)
//   in_load_valid       write one table entry (IDLE only)
//   in_load_from/to     signed segment bounds, from must be <= to
//   in_load_type        segment type (1=EXPDOWN, 2=EXPUP, 3=UNIFORM)
//   in_load_weight      unsigned weight, 0 = never chosen
//   out_load_ready      table accepts writes
//   in_start            request one selection (IDLE only)
//   out_busy            selection in progress or result pending
//   out_valid           chosen segment fields valid
//   in_ready            Sampler consumed result
//   out_from/out_to     chosen segment bounds
//   out_segment_type    chosen segment type
//   out_segment_weight  chosen segment weight
//   out_segment_index   chosen table index
//   out_error           one-cycle pulse on rejected load or zero-weight start
//   out_state           current FSM state (0=IDLE 1=DRAW 2=SCAN 3=PRESENT)
// -----------------------------------------------------------------------------
module segment_selector #(
    parameter int MAX_SEGMENTS = 4,
    parameter int DATA_WIDTH   = 8,
    parameter int WEIGHT_WIDTH = 8,
    parameter int SUM_WIDTH    = 11
) (
    input  logic                    in_clock,
    input  logic                    in_reset,
    input  logic [7:0]              in_seed,
    input  logic                    in_load_clear,
    input  logic                    in_load_valid,
    input  logic [DATA_WIDTH-1:0]   in_load_from,
    input  logic [DATA_WIDTH-1:0]   in_load_to,
    input  logic [1:0]              in_load_type,
    input  logic [WEIGHT_WIDTH-1:0] in_load_weight,
    output logic                    out_load_ready,
    input  logic                    in_start,
    output logic                    out_busy,
    output logic                    out_valid,
    input  logic                    in_ready,
    output logic [DATA_WIDTH-1:0]   out_from,
    output logic [DATA_WIDTH-1:0]   out_to,
    output logic [1:0]              out_segment_type,
    output logic [WEIGHT_WIDTH-1:0] out_segment_weight,
    output logic [2:0]              out_segment_index,
    output logic                    out_error,
    output logic [1:0]              out_state
);

    // Count register must hold 0..MAX_SEGMENTS. Table index needs 0..MAX-1.
    localparam int CW = $clog2(MAX_SEGMENTS + 1);
    localparam int IW = $clog2(MAX_SEGMENTS);
    localparam logic [CW-1:0] MAX_CNT = CW'(MAX_SEGMENTS);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_DRAW    = 2'd1,
        S_SCAN    = 2'd2,
        S_PRESENT = 2'd3
    } state_t;

    state_t state;
    state_t state_next;

    // Segment table
    logic [DATA_WIDTH-1:0]   tbl_from   [MAX_SEGMENTS];
    logic [DATA_WIDTH-1:0]   tbl_to     [MAX_SEGMENTS];
    logic [1:0]              tbl_type   [MAX_SEGMENTS];
    logic [WEIGHT_WIDTH-1:0] tbl_weight [MAX_SEGMENTS];

    logic [CW-1:0]        count;
    logic [SUM_WIDTH-1:0] total;

    // Random source and scan datapath
    logic [7:0]           lfsr;
    logic                 lfsr_fb;
    logic [7:0]           lfsr_next;
    logic [SUM_WIDTH+7:0] draw_prod;
    logic [SUM_WIDTH-1:0] draw_r;
    logic [SUM_WIDTH-1:0] r_q;
    logic [CW-1:0]        idx;
    logic [IW-1:0]        idx_sel;
    logic                 idx_valid;
    logic [SUM_WIDTH-1:0] cum;
    logic [SUM_WIDTH-1:0] cum_next;
    logic [WEIGHT_WIDTH-1:0] w_cur;
    logic                 hit;

    // IDLE-side decode
    logic load_ok_range;
    logic load_ready_int;
    logic start_go;
    logic start_zero;

    // ------------------------------------------------------------------
    // Combinational datapath helpers
    // ------------------------------------------------------------------
    // Fibonacci LFSR, taps 8,6,5,4 (maximal length, period 255).
    assign lfsr_fb   = lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3];
    assign lfsr_next = {lfsr[6:0], lfsr_fb};

    // Scaling by total then dropping 8 bits maps the 8-bit draw into
    // [0, total). The product is kept at full width so nothing wraps.
    always_comb begin
        draw_prod = {{SUM_WIDTH{1'b0}}, lfsr_next} * {8'd0, total};
        draw_r    = draw_prod[SUM_WIDTH+7:8];
    end

    // idx can equal count (== MAX_SEGMENTS) when the scan is exhausted.
    // idx_sel may alias entry 0 then, but idx_valid masks it.
    assign idx_valid = (idx < count);
    assign idx_sel   = idx[IW-1:0];
    assign w_cur     = tbl_weight[idx_sel];
    assign cum_next  = cum + {{(SUM_WIDTH-WEIGHT_WIDTH){1'b0}}, w_cur};
    // A zero weight leaves cum unchanged. Its range is therefore empty.
    assign hit       = idx_valid && (w_cur != '0) && (r_q < cum_next);

    assign load_ok_range  = ($signed(in_load_from) <= $signed(in_load_to));
    assign load_ready_int = (state == S_IDLE) && (count < MAX_CNT);
    // A start request is honoured only if no clear or load is present
    // in the same cycle.
    assign start_go   = in_start && !in_load_clear && !in_load_valid && (total != '0);
    assign start_zero = in_start && !in_load_clear && !in_load_valid && (total == '0);

    // ------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------
    always_ff @(posedge in_clock) begin
        if (!in_reset) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // ------------------------------------------------------------------
    // FSM: next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        state_next = state;
        case (state)
            S_IDLE: begin
                if (start_go) begin
                    state_next = S_DRAW;
                end
            end
            S_DRAW: begin
                state_next = S_SCAN;
            end
            S_SCAN: begin
                // Running off the end cannot happen while r < total.
                // Falling back to IDLE keeps the FSM from hanging anyway.
                if (!idx_valid) begin
                    state_next = S_IDLE;
                end else if (hit) begin
                    state_next = S_PRESENT;
                end
            end
            S_PRESENT: begin
                if (out_valid && in_ready) begin
                    state_next = S_IDLE;
                end
            end
            default: state_next = S_IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // FSM: state-decoded outputs
    // ------------------------------------------------------------------
    always_comb begin
        out_busy       = (state != S_IDLE);
        out_load_ready = load_ready_int;
        out_state      = state;
    end

    // ------------------------------------------------------------------
    // Table, LFSR, scan registers and result registers
    // ------------------------------------------------------------------
    always_ff @(posedge in_clock) begin
        if (!in_reset) begin
            lfsr               <= (in_seed == 8'd0) ? 8'h01 : in_seed;
            count              <= '0;
            total              <= '0;
            r_q                <= '0;
            idx                <= '0;
            cum                <= '0;
            out_valid          <= 1'b0;
            out_error          <= 1'b0;
            out_from           <= '0;
            out_to             <= '0;
            out_segment_type   <= '0;
            out_segment_weight <= '0;
            out_segment_index  <= '0;
        end else begin
            out_error <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (in_load_clear) begin
                        count <= '0;
                        total <= '0;
                    end else if (in_load_valid) begin
                        if (!load_ok_range) begin
                            out_error <= 1'b1;
                        end else if (load_ready_int) begin
                            tbl_from[count[IW-1:0]]   <= in_load_from;
                            tbl_to[count[IW-1:0]]     <= in_load_to;
                            tbl_type[count[IW-1:0]]   <= in_load_type;
                            tbl_weight[count[IW-1:0]] <= in_load_weight;
                            count <= count + CW'(1);
                            total <= total + {{(SUM_WIDTH-WEIGHT_WIDTH){1'b0}}, in_load_weight};
                        end
                        // A full table drops the entry without flagging it.
                    end else if (start_zero) begin
                        out_error <= 1'b1;
                    end
                end
                S_DRAW: begin
                    lfsr <= lfsr_next;
                    r_q  <= draw_r;
                    idx  <= '0;
                    cum  <= '0;
                end
                S_SCAN: begin
                    if (idx_valid) begin
                        cum <= cum_next;
                        if (hit) begin
                            out_from           <= tbl_from[idx_sel];
                            out_to             <= tbl_to[idx_sel];
                            out_segment_type   <= tbl_type[idx_sel];
                            out_segment_weight <= w_cur;
                            out_segment_index  <= 3'(idx_sel);
                        end else begin
                            idx <= idx + CW'(1);
                        end
                    end
                end
                S_PRESENT: begin
                    // The fields were latched on the hit edge. Valid is raised
                    // one edge later, so the fields are settled a full cycle
                    // before the Sampler can see them.
                    if (!out_valid) begin
                        out_valid <= 1'b1;
                    end else if (in_ready) begin
                        out_valid <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_segment_selector.sv
module tb_segment_selector;

  logic       clk;
  logic       rst_n;
  logic [7:0] seed;
  logic       load_clear;
  logic       load_valid;
  logic [7:0] load_from;
  logic [7:0] load_to;
  logic [1:0] load_type;
  logic [7:0] load_weight;
  logic       load_ready;
  logic       start;
  logic       busy;
  logic       valid;
  logic       ready;
  logic [7:0] seg_from;
  logic [7:0] seg_to;
  logic [1:0] seg_type;
  logic [7:0] seg_weight;
  logic [2:0] seg_index;
  logic       error;
  logic [1:0] state;

  int checks = 0;
  int errors = 0;
  logic [2:0] exp_q[$];
  int idx_hist[400];

  segment_selector #(
    .MAX_SEGMENTS(4),
    .DATA_WIDTH(8),
    .WEIGHT_WIDTH(8),
    .SUM_WIDTH(11)
  ) dut (
    .in_clock(clk),
    .in_reset(rst_n),
    .in_seed(seed),
    .in_load_clear(load_clear),
    .in_load_valid(load_valid),
    .in_load_from(load_from),
    .in_load_to(load_to),
    .in_load_type(load_type),
    .in_load_weight(load_weight),
    .out_load_ready(load_ready),
    .in_start(start),
    .out_busy(busy),
    .out_valid(valid),
    .in_ready(ready),
    .out_from(seg_from),
    .out_to(seg_to),
    .out_segment_type(seg_type),
    .out_segment_weight(seg_weight),
    .out_segment_index(seg_index),
    .out_error(error),
    .out_state(state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog expired checks=%0d", checks);
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // driver tasks: every call leaves time at 1ns after a posedge
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset(input logic [7:0] s);
    rst_n = 1'b0;
    seed  = s;
    step();
    rst_n = 1'b1;
  endtask

  task automatic load(input logic [7:0] f, input logic [7:0] t, input logic [1:0] ty, input logic [7:0] w);
    load_valid  = 1'b1;
    load_from   = f;
    load_to     = t;
    load_type   = ty;
    load_weight = w;
    step();
    load_valid  = 1'b0;
  endtask

  task automatic start_sel();
    start = 1'b1;
    step();
    start = 1'b0;
  endtask

  task automatic wait_valid(output int n);
    n = 0;
    while (!valid && n < 12) begin
      step();
      n++;
    end
    if (!valid) check("valid_timeout", 32'(valid), 32'd1);
  endtask

  task automatic consume();
    ready = 1'b1;
    step();
    ready = 1'b0;
  endtask

  initial begin
    int n;
    int ones;
    int rep_bad;
    logic [2:0] e;

    rst_n = 1'b1; seed = 8'd0; load_clear = 1'b0; load_valid = 1'b0;
    load_from = '0; load_to = '0; load_type = '0; load_weight = '0;
    start = 1'b0; ready = 1'b0;
    step();

    // ---------------- reset state ----------------
    do_reset(8'd4);
    check("rst_valid", 32'(valid), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_load_ready", 32'(load_ready), 32'd1);
    check("rst_error", 32'(error), 32'd0);
    check("rst_state", 32'(state), 32'd0);
    check("rst_index", 32'(seg_index), 32'd0);

    // ---------------- single segment + backpressure ----------------
    load(8'd0, 8'd50, 2'd1, 8'd7);
    start_sel();                      // edge T
    check("s1_busy_T", 32'(busy), 32'd1);
    check("s1_valid_T", 32'(valid), 32'd0);
    step(); step();                   // T+2
    check("s1_valid_T2", 32'(valid), 32'd0);
    step();                           // T+3
    check("s1_valid_T3", 32'(valid), 32'd1);
    check("s1_from", 32'(seg_from), 32'd0);
    check("s1_to", 32'(seg_to), 32'd50);
    check("s1_type", 32'(seg_type), 32'd1);
    check("s1_weight", 32'(seg_weight), 32'd7);
    check("s1_index", 32'(seg_index), 32'd0);
    for (int i = 0; i < 4; i++) begin
      step();
      check("bp_valid", 32'(valid), 32'd1);
      check("bp_to", 32'(seg_to), 32'd50);
      check("bp_weight", 32'(seg_weight), 32'd7);
    end
    consume();
    check("hs_valid", 32'(valid), 32'd0);
    check("hs_busy", 32'(busy), 32'd0);
    check("hs_load_ready", 32'(load_ready), 32'd1);
    check("hs_retain_to", 32'(seg_to), 32'd50);

    // ---------------- weight-0 skip ----------------
    do_reset(8'd4);
    load(8'd0, 8'd10, 2'd1, 8'd0);
    load(8'd0, 8'd10, 2'd2, 8'd0);
    load(8'hEC, 8'hFD, 2'd3, 8'd5);   // -20 .. -3
    start_sel();
    step(); step(); step(); step();   // T+4
    check("w0_valid_T4", 32'(valid), 32'd0);
    step();                           // T+5
    check("w0_valid_T5", 32'(valid), 32'd1);
    check("w0_index", 32'(seg_index), 32'd2);
    check("w0_from", 32'(seg_from), 32'hEC);
    check("w0_to", 32'(seg_to), 32'hFD);
    check("w0_type", 32'(seg_type), 32'd3);
    consume();

    // ---------------- errors ----------------
    do_reset(8'd4);
    start_sel();
    check("err_empty_pulse", 32'(error), 32'd1);
    check("err_empty_busy", 32'(busy), 32'd0);
    step();
    check("err_empty_clear", 32'(error), 32'd0);
    check("err_empty_valid", 32'(valid), 32'd0);
    load(8'd10, 8'd5, 2'd1, 8'd3);
    check("err_range_pulse", 32'(error), 32'd1);
    step();
    check("err_range_clear", 32'(error), 32'd0);
    start_sel();                      // table still empty -> error again
    check("err_range_nocount", 32'(error), 32'd1);
    check("err_range_state", 32'(state), 32'd0);

    // ---------------- full table ----------------
    do_reset(8'd4);
    for (int i = 0; i < 4; i++) begin
      check("full_ready_before", 32'(load_ready), 32'd1);
      load(8'(i * 10), 8'(i * 10 + 5), 2'd3, 8'd1);
    end
    check("full_ready_after4", 32'(load_ready), 32'd0);
    load(8'd100, 8'd120, 2'd2, 8'd200);
    check("full_5th_noerr", 32'(error), 32'd0);
    // lfsr 4 -> 8, r = 8*4>>8 = 0 -> entry 0 (a wrongly kept 5th entry gives r=6 -> idx 4)
    start_sel();
    wait_valid(n);
    check("full_index", 32'(seg_index), 32'd0);
    check("full_from", 32'(seg_from), 32'd0);
    consume();

    // ---------------- distribution ----------------
    do_reset(8'd4);
    load(8'd0, 8'd1, 2'd3, 8'd1);
    load(8'd2, 8'd3, 2'd3, 8'd3);
    // lfsr 8, 17, 35, 71 -> r = v>>6 = 0,0,0,1
    exp_q.push_back(3'd0);
    exp_q.push_back(3'd0);
    exp_q.push_back(3'd0);
    exp_q.push_back(3'd1);
    ones = 0;
    for (int i = 0; i < 400; i++) begin
      start_sel();
      wait_valid(n);
      idx_hist[i] = int'(seg_index);
      if (seg_index == 3'd1) ones++;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check("dist_seq", 32'(seg_index), 32'(e));
        check("dist_latency", 32'(n), 32'(3 + int'(e)));
      end
      consume();
    end
    check("dist_ones_range", 32'((ones >= 250) && (ones <= 350)), 32'd1);
    rep_bad = 0;
    for (int i = 0; i < 145; i++) begin
      if (idx_hist[i] != idx_hist[i + 255]) rep_bad++;
    end
    check("dist_period255", 32'(rep_bad), 32'd0);

    // ---------------- reset mid-SCAN ----------------
    do_reset(8'd4);
    load(8'd0, 8'd10, 2'd1, 8'd0);
    load(8'd0, 8'd10, 2'd2, 8'd0);
    load(8'hEC, 8'hFD, 2'd3, 8'd5);
    start_sel();                      // T: DRAW
    step();                           // T+1: SCAN
    check("mid_in_scan", 32'(state), 32'd2);
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    check("mid_state", 32'(state), 32'd0);
    check("mid_valid", 32'(valid), 32'd0);
    check("mid_busy", 32'(busy), 32'd0);
    check("mid_load_ready", 32'(load_ready), 32'd1);
    start_sel();
    check("mid_empty_error", 32'(error), 32'd1);
    step();
    step();
    check("mid_still_idle", 32'(valid), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
